// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared owner encodings and default bus widths for the data-RAM port
package ram_port_arbiter_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DISP = 2'd2
    } owner_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - CPU-priority arbiter for the data-RAM port with scanner starvation guard
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              data_ram_we,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    owner_t           owner_q;
    owner_t           owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_d;

    always_comb begin
        cpu_ack     = 1'b0;
        disp_ack    = 1'b0;
        ram_addr    = '0;
        data_ram_we = 1'b0;
        owner_d     = OWN_NONE;
        starve_d    = starve_cnt;
        if (!rst) begin
            if (disp_req && (!cpu_req || starve_cnt == STARVE_LIM)) begin
                disp_ack = 1'b1;
                ram_addr = disp_addr;
                owner_d  = OWN_DISP;
            end else if (cpu_req) begin
                cpu_ack     = 1'b1;
                ram_addr    = cpu_addr;
                data_ram_we = cpu_we;
                if (!cpu_we) begin
                    owner_d = OWN_CPU;
                end
            end
        end
        // Counts CPU grants the scanner has sat through; saturation forces the scanner's turn.
        if (!disp_req || disp_ack) begin
            starve_d = '0;
        end else if (cpu_ack && starve_cnt != STARVE_LIM) begin
            starve_d = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
        end
    end

    // Gating with rst drops a read granted just before reset in the reset cycle itself.
    assign cpu_rvalid  = !rst && (owner_q == OWN_CPU);
    assign disp_rvalid = !rst && (owner_q == OWN_DISP);
    assign cpu_rdata   = ram_data_out;
    assign disp_rdata  = ram_data_out;
    assign ram_data_in = cpu_wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter against a behavioural model
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_ack, disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic          data_ram_we;
    logic [DW-1:0] ram_data_out;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .data_ram_we(data_ram_we),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM stub
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_data_out <= ram[ram_addr];
        if (data_ram_we) ram[ram_addr] <= ram_data_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t cq[$];
    exp_t dq[$];
    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            wait_cnt = 0;
    int            disp_acks = 0;

    logic          c_pend = 1'b0, c_we = 1'b0, d_pend = 1'b0, rst_next = 1'b1;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic run_cycle();
        logic dg, cg;
        logic [AW-1:0] ea;
        exp_t e;
        @(posedge clk);
        #1;
        rst       = rst_next;
        cpu_req   = c_pend;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        disp_req  = d_pend;
        disp_addr = d_addr;
        @(negedge clk);
        if (rst) begin
            dg = 1'b0;
            cg = 1'b0;
        end else begin
            dg = d_pend && (!c_pend || wait_cnt == SM);
            cg = !dg && c_pend;
        end
        ea = dg ? d_addr : (cg ? c_addr : '0);
        check("cpu_ack", DW'(cpu_ack), DW'(cg));
        check("disp_ack", DW'(disp_ack), DW'(dg));
        check("data_ram_we", DW'(data_ram_we), DW'(cg && c_we));
        check("ram_addr", DW'(ram_addr), DW'(ea));
        check("ram_data_in", ram_data_in, c_wdata);
        if (disp_ack) disp_acks++;
        if (cg && !c_we) begin
            e.data = ref_mem[c_addr];
            e.due  = cyc + 1;
            cq.push_back(e);
        end
        if (cg && c_we) ref_mem[c_addr] = c_wdata;
        if (dg) begin
            e.data = ref_mem[d_addr];
            e.due  = cyc + 1;
            dq.push_back(e);
        end
        if (rst || dg || !d_pend) wait_cnt = 0;
        else if (cg && wait_cnt < SM) wait_cnt++;
        if (cg) c_pend = 1'b0;
        if (dg) d_pend = 1'b0;
    endtask

    task automatic cpu_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_pend = 1'b1; c_we = we; c_addr = a; c_wdata = d;
    endtask

    task automatic disp_issue(input logic [AW-1:0] a);
        d_pend = 1'b1; d_addr = a;
    endtask

    // Monitor: pops the scoreboard whenever a read-data valid is due or presented
    always @(negedge clk) begin
        if (rst) begin
            check("cpu_rvalid_rst", DW'(cpu_rvalid), '0);
            check("disp_rvalid_rst", DW'(disp_rvalid), '0);
            while (cq.size() > 0 && cq[0].due <= cyc) void'(cq.pop_front());
            while (dq.size() > 0 && dq[0].due <= cyc) void'(dq.pop_front());
        end else begin
            if (cpu_rvalid || (cq.size() > 0 && cq[0].due <= cyc)) begin
                if (cq.size() == 0 || cq[0].due != cyc || !cpu_rvalid) begin
                    check("cpu_rvalid_timing", DW'(cpu_rvalid), DW'(!cpu_rvalid));
                    if (cq.size() > 0 && cq[0].due <= cyc) void'(cq.pop_front());
                end else begin
                    check("cpu_rdata", cpu_rdata, cq[0].data);
                    void'(cq.pop_front());
                end
            end
            if (disp_rvalid || (dq.size() > 0 && dq[0].due <= cyc)) begin
                if (dq.size() == 0 || dq[0].due != cyc || !disp_rvalid) begin
                    check("disp_rvalid_timing", DW'(disp_rvalid), DW'(!disp_rvalid));
                    if (dq.size() > 0 && dq[0].due <= cyc) void'(dq.pop_front());
                end else begin
                    check("disp_rdata", disp_rdata, dq[0].data);
                    void'(dq.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        rst_next = 1'b1;
        run_cycle();
        run_cycle();
        rst_next = 1'b0;
        run_cycle();

        // CPU write then read of the same word
        cpu_issue(1'b1, AW'(5), DW'(32'h666));
        run_cycle();
        run_cycle();
        cpu_issue(1'b0, AW'(5), '0);
        run_cycle();
        run_cycle();

        // Scanner sweeps the 16 cells back to back
        for (int i = 0; i < 16; i++) begin
            disp_issue(AW'(i));
            run_cycle();
        end
        run_cycle();

        // Both held: scanner gets every fifth grant
        disp_acks = 0;
        for (int i = 0; i < 25; i++) begin
            if (!c_pend) cpu_issue(1'b0, AW'($urandom_range(0, 31)), '0);
            if (!d_pend) disp_issue(AW'($urandom_range(0, 15)));
            run_cycle();
        end
        check("starve_pattern_disp_acks", DW'(disp_acks), DW'(5));
        c_pend = 1'b0;
        d_pend = 1'b0;
        run_cycle();

        // Scanner read granted, then reset in the following cycle
        disp_issue(AW'(3));
        run_cycle();
        rst_next = 1'b1;
        run_cycle();
        rst_next = 1'b0;
        cpu_issue(1'b0, AW'(9), '0);
        disp_issue(AW'(4));
        run_cycle();
        run_cycle();
        run_cycle();

        // Read then write to the same address back to back
        cpu_issue(1'b0, AW'(7), '0);
        run_cycle();
        cpu_issue(1'b1, AW'(7), DW'(32'hCAFE_0007));
        run_cycle();
        cpu_issue(1'b0, AW'(7), '0);
        run_cycle();
        run_cycle();

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if (!c_pend && $urandom_range(0, 3) != 0)
                cpu_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
            if (!d_pend && $urandom_range(0, 2) != 0)
                disp_issue(AW'($urandom_range(0, 31)));
            rst_next = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        rst_next = 1'b0;
        c_pend = 1'b0;
        d_pend = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();

        check("cpu_queue_drained", DW'(cq.size()), '0);
        check("disp_queue_drained", DW'(dq.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
